// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: run-time reconfigurable clock-enable generator / divider.
// Produces a one-cycle tick per period and a near-50% duty clk_out. New
// divisors loaded while running are held in a shadow register and applied
// only at a period boundary so the output never produces a runt pulse.
module freq_div_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 195312
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_divisor,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [WIDTH-1:0] div_active,
    output logic             pending,
    output logic             tick,
    output logic             clk_out
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TWO     = ONE << 1;
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q,      state_d;
    logic [WIDTH-1:0] cnt_q,        cnt_d;
    logic [WIDTH-1:0] div_active_q, div_active_d;
    logic [WIDTH-1:0] shadow_q,     shadow_d;
    logic             pending_q,    pending_d;
    logic             tick_q,       tick_d;
    logic             clk_out_q,    clk_out_d;
    logic             cfg_err_q,    cfg_err_d;

    logic             xfer;
    logic             div_bad;
    logic             wrap;
    logic [WIDTH-1:0] high_len;

    assign xfer    = cfg_valid && !pending_q;
    assign div_bad = (cfg_divisor < TWO);
    assign wrap    = (cnt_q == (div_active_q - ONE));

    // Next-state computation for the run/idle FSM, counter, config path and outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_active_d = div_active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        cfg_err_d    = xfer && div_bad;
        tick_d       = 1'b0;
        clk_out_d    = 1'b0;
        high_len     = '0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (xfer && !div_bad) begin
                    div_active_d = cfg_divisor;
                end
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    // Stop edge: any pending divisor (or one transferred on this
                    // very edge) takes effect directly since no period follows.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (pending_q) begin
                        div_active_d = shadow_q;
                        pending_d    = 1'b0;
                    end else if (xfer && !div_bad) begin
                        div_active_d = cfg_divisor;
                    end
                end else begin
                    if (wrap) begin
                        cnt_d = '0;
                        if (pending_q) begin
                            div_active_d = shadow_q;
                            pending_d    = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                    // pending_q is 0 whenever xfer is set, so a divisor taken on a
                    // wrap edge waits for the following wrap.
                    if (xfer && !div_bad) begin
                        shadow_d  = cfg_divisor;
                        pending_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (state_d == ST_RUN) begin
            high_len  = div_active_d - (div_active_d >> 1);
            tick_d    = (cnt_d == (div_active_d - ONE));
            clk_out_d = (cnt_d < high_len);
        end
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            div_active_q <= DEF_DIV;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            tick_q       <= 1'b0;
            clk_out_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_active_q <= div_active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            tick_q       <= tick_d;
            clk_out_q    <= clk_out_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cfg_ready  = !pending_q;
    assign cfg_err    = cfg_err_q;
    assign div_active = div_active_q;
    assign pending    = pending_q;
    assign tick       = tick_q;
    assign clk_out    = clk_out_q;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed testbench for freq_div_ctrl with hand-computed expected values.
module tb_freq_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_valid;
    logic [31:0] cfg_divisor;
    logic        cfg_ready;
    logic        cfg_err;
    logic [31:0] div_active;
    logic        pending;
    logic        tick;
    logic        clk_out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    freq_div_ctrl #(
        .WIDTH       (32),
        .DEFAULT_DIV (195312)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_divisor (cfg_divisor),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .div_active  (div_active),
        .pending     (pending),
        .tick        (tick),
        .clk_out     (clk_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step n cycles, comparing clk_out/tick against bit patterns (index 0 first).
    task automatic run_pattern(input string tag, input int n,
                               input logic [0:15] clk_pat, input logic [0:15] tick_pat);
        for (int i = 0; i < n; i++) begin
            step();
            check($sformatf("%s_clk%0d", tag, i), 32'(clk_out), 32'(clk_pat[i]));
            check($sformatf("%s_tick%0d", tag, i), 32'(tick), 32'(tick_pat[i]));
        end
    endtask

    task automatic load_idle(input logic [31:0] n);
        cfg_valid   = 1'b1;
        cfg_divisor = n;
        step();
        cfg_valid   = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        cfg_valid   = 1'b0;
        cfg_divisor = '0;
        #1;
        check("rst_div", div_active, 32'd195312);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        step();
        reset = 1'b0;

        // N = 4: after E0 cnt=0; clk_out 1,1,0,0; tick at cnt=3
        load_idle(32'd4);
        check("idle_load4_div", div_active, 32'd4);
        check("idle_load4_pend", 32'(pending), 32'd0);
        enable = 1'b1;
        run_pattern("n4", 9, 16'b1100_1100_1000_0000, 16'b0001_0001_0000_0000);
        enable = 1'b0;
        step();
        check("stop_tick", 32'(tick), 32'd0);
        check("stop_clk", 32'(clk_out), 32'd0);

        // N = 5: clk_out 1,1,1,0,0; tick at cnt=4
        load_idle(32'd5);
        check("idle_load5_div", div_active, 32'd5);
        enable = 1'b1;
        run_pattern("n5", 10, 16'b1110_0111_0000_0000, 16'b0000_1000_0100_0000);
        enable = 1'b0;
        step();

        // Mid-run reconfigure: N=4, accept 6 on edge where cnt becomes 1
        load_idle(32'd4);
        enable = 1'b1;
        step();                                   // cnt=0
        cfg_valid   = 1'b1;
        cfg_divisor = 32'd6;
        step();                                   // cnt=1, transfer
        cfg_valid   = 1'b0;
        check("mid_pend", 32'(pending), 32'd1);
        check("mid_ready", 32'(cfg_ready), 32'd0);
        check("mid_div_old", div_active, 32'd4);
        step();                                   // cnt=2
        check("mid_pend2", 32'(pending), 32'd1);
        check("mid_clk2", 32'(clk_out), 32'd0);
        step();                                   // cnt=3, old period ends
        check("mid_tick3", 32'(tick), 32'd1);
        check("mid_pend3", 32'(pending), 32'd1);
        step();                                   // wrap: apply 6
        check("mid_div_new", div_active, 32'd6);
        check("mid_pend_clr", 32'(pending), 32'd0);
        check("mid_ready_back", 32'(cfg_ready), 32'd1);
        check("mid_clk0", 32'(clk_out), 32'd1);
        check("mid_tick0", 32'(tick), 32'd0);
        // cnt 1..5 then 0..5: clk 1,1,0,0,0 | 1,1,1,0,0,0 ; tick at cnt=5
        run_pattern("n6", 11, 16'b1100_0111_0000_0000, 16'b0000_1000_0010_0000);
        enable = 1'b0;
        step();

        // Accept N=3 on a wrap edge while running at N=4
        load_idle(32'd4);
        enable = 1'b1;
        step();                                   // cnt=0
        step();                                   // cnt=1
        step();                                   // cnt=2
        step();                                   // cnt=3
        check("wrp_tick_pre", 32'(tick), 32'd1);
        cfg_valid   = 1'b1;
        cfg_divisor = 32'd3;
        step();                                   // wrap edge, transfer
        cfg_valid   = 1'b0;
        check("wrp_pend", 32'(pending), 32'd1);
        check("wrp_div_old", div_active, 32'd4);
        // one more full 4-period (cnt 1,2,3) then 3-periods (cnt 0,1,2,0,1,2)
        run_pattern("wrp", 9, 16'b1001_1011_0000_0000, 16'b0010_0100_1000_0000);
        check("wrp_div_new", div_active, 32'd3);
        check("wrp_pend_clr", 32'(pending), 32'd0);

        // Rejected divisors while running: 1 then 0 (valid held)
        cfg_valid   = 1'b1;
        cfg_divisor = 32'd1;
        step();
        check("rej1_err", 32'(cfg_err), 32'd1);
        check("rej1_div", div_active, 32'd3);
        check("rej1_pend", 32'(pending), 32'd0);
        cfg_divisor = 32'd0;
        step();
        cfg_valid = 1'b0;
        check("rej0_err", 32'(cfg_err), 32'd1);
        check("rej0_div", div_active, 32'd3);
        step();
        check("rej_err_clr", 32'(cfg_err), 32'd0);

        // Stop with N=8 pending
        cfg_valid   = 1'b1;
        cfg_divisor = 32'd8;
        step();
        cfg_valid = 1'b0;
        check("stp_pend", 32'(pending), 32'd1);
        enable = 1'b0;
        step();
        check("stp_div", div_active, 32'd8);
        check("stp_pend_clr", 32'(pending), 32'd0);
        check("stp_tick", 32'(tick), 32'd0);
        check("stp_clk", 32'(clk_out), 32'd0);

        // Asynchronous reset mid-run with a divisor pending
        enable = 1'b1;
        step();
        step();
        cfg_valid   = 1'b1;
        cfg_divisor = 32'd7;
        step();
        cfg_valid = 1'b0;
        check("ar_pend_pre", 32'(pending), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_tick", 32'(tick), 32'd0);
        check("ar_clk", 32'(clk_out), 32'd0);
        check("ar_err", 32'(cfg_err), 32'd0);
        check("ar_div", div_active, 32'd195312);
        check("ar_pend", 32'(pending), 32'd0);
        check("ar_ready", 32'(cfg_ready), 32'd1);
        step();
        reset = 1'b0;
        step();
        check("ar_idle_after", 32'(clk_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/freq_div_ctrl.md
# freq_div_ctrl

Programmable, run-time reconfigurable clock-enable generator and divider controller. Divides the system clock by a divisor loaded over a valid/ready configuration port and emits a one-cycle `tick` enable plus a near-50%-duty `clk_out` square wave. It sits between the configuration/register logic and any consumer of a slow timebase, such as the 256 Hz display or debounce strobe. New divisors are applied only at a period boundary, so the output never produces a runt pulse.

## Interface
- `WIDTH`, 32: counter and divisor width in bits.
- `DEFAULT_DIV`, 195312: divisor loaded at reset. 50 MHz → 256 Hz. Must be ≥ 2.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: run request. 1 = count, 0 = idle.
- `cfg_valid` in 1: a configuration word is offered.
- `cfg_divisor` in WIDTH: requested divisor N.
- `cfg_ready` out 1: controller can accept a configuration word.
- `cfg_err` out 1: one-cycle pulse when an offered divisor is rejected.
- `div_active` out WIDTH: divisor currently in effect.
- `pending` out 1: an accepted divisor is waiting for a period boundary.
- `tick` out 1: high exactly one cycle per period.
- `clk_out` out 1: divided square wave.

## Operation
- **States.**
  - IDLE: `cnt` = 0, `tick` = 0, `clk_out` = 0.
  - RUN: `cnt` counts 0..`div_active`−1 and wraps.
- **Transitions.**
  - IDLE→RUN when `enable` = 1 is sampled.
  - RUN→IDLE when `enable` = 0 is sampled. `cnt`, `tick` and `clk_out` clear on that same edge.
- **Counter.** In RUN, the next `cnt` is 0 if `cnt` = `div_active`−1, otherwise `cnt`+1. Arithmetic is unsigned, WIDTH bits. Count never exceeds `div_active`−1.
- **Registered outputs.**
  - `tick` = 1 iff the next `cnt` equals `div_active`−1.
  - `clk_out` = 1 iff the next `cnt` < `div_active` − (`div_active`>>1). For odd N, high lasts (N+1)/2 cycles and low lasts (N−1)/2 cycles.
- **Config handshake.**
  - A transfer occurs on any edge where `cfg_valid` && `cfg_ready`.
  - `cfg_ready` = !`pending`.
  - `cfg_valid` may be held. Data is sampled only on the transfer edge.
- **Divisor < 2.**
  - The transfer completes but is discarded.
  - `cfg_err` = 1 for the following cycle.
  - `div_active` and `pending` are unchanged.
- **Valid divisor accepted in IDLE.** `div_active` ← N on the transfer edge; `pending` stays 0.
- **Valid divisor accepted in RUN.**
  - Stored in a shadow register; `pending` ← 1.
  - Applied on the first wrap edge strictly after the transfer edge: `div_active` ← shadow, `pending` ← 0, and the new period starts with `cnt` = 0.
  - If the transfer edge is itself a wrap edge, the old divisor runs one more full period.
- **Pending divisor and RUN→IDLE.** A pending divisor is applied on the RUN→IDLE edge.
- **Reset values** (asynchronous, takes effect immediately):
  - state = IDLE, `cnt` = 0
  - `tick` = 0, `clk_out` = 0, `cfg_err` = 0
  - `div_active` = `DEFAULT_DIV`, `pending` = 0, `cfg_ready` = 1
  - The shadow register is cleared; any pending divisor is discarded.

## Timing
- **Start latency.** With `enable` = 1 sampled at edge E0, the state after E0 is RUN with `cnt` = 0 and `clk_out` = 1. The first `tick` is after edge E0+N−1. Thereafter the `tick` period is exactly N cycles.
- **Stop latency.** `tick` and `clk_out` are 0 one edge after `enable` = 0 is sampled.
- **Config latency.**
  - In IDLE: 1 edge.
  - In RUN: at most N_old edges from the transfer edge to `div_active` update.
- **Back-pressure.** `cfg_ready` returns to 1 the cycle after the apply edge. The earliest next transfer is on the edge after that.
- **Reset deassertion.** Reset release is synchronized by the system. The first edge after release evaluates `enable` normally.

## Test plan
- **Reset defaults.** Assert reset mid-RUN with a divisor pending → all outputs equal their reset values immediately, before any clock edge. `div_active` = 195312 and `pending` = 0.
- **Run with N = 4.** Load N = 4 in IDLE, then enable → `clk_out` pattern 1,1,0,0 repeating. `tick` is high on every 4th cycle, aligned with `cnt` = 3.
- **Run with N = 5.** Same as above with N = 5 → `clk_out` 1,1,1,0,0. `tick` period is 5.
- **Mid-run reconfigure.** Running at N = 4, accept N = 6 on the edge where `cnt` becomes 1 → `pending` = 1 and `cfg_ready` = 0 until the wrap. The remaining old period completes; the next period is 6 cycles; `div_active` = 6.
- **Accept on a wrap edge.** Accept N = 3 on a wrap edge while running at N = 4 → one more 4-cycle period, then 3-cycle periods.
- **Rejected divisors and stop with pending.**
  - Offer N = 1, then N = 0 → each is accepted with `cfg_err` pulsing one cycle; `div_active` is unchanged.
  - With N = 8 pending, drop `enable` → IDLE on the next edge with `div_active` = 8 and `tick` = `clk_out` = 0.
